// File: rtl/vertex_affine_transformer.sv
// vertex_affine_transformer
//   Per-primitive affine transform of VERTS vertices in signed fixed point
//   (FRAC_W fractional bits). mode = 0 computes R^T * (p - vec) (camera),
//   mode = 1 computes R * p + vec (model). Positions, colours, matrix, vector
//   and mode are captured on accept; vertices then stream one per cycle
//   through a translate / multiply-accumulate / round-saturate pipeline.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_pos             VERTS x {x,y,z}, vertex k axis a at [(3k+a)*W +: W]
//   in_color           VERTS colours, vertex k at [k*COLOR_W +: COLOR_W]
//   in_valid/in_ready  input primitive handshake
//   mode               0 = camera transform, 1 = model transform
//   r_mat              Rij at [(3(i-1)+(j-1))*W +: W], row-major
//   vec                C (mode 0) or T (mode 1), axis a at [a*W +: W]
//   out_pos/out_color  transformed positions and pass-through colours
//   out_sat            some component of this primitive saturated
//   out_valid/out_ready output primitive handshake
//   busy               high whenever not idle
module vertex_affine_transformer #(
    parameter int W       = 32,
    parameter int FRAC_W  = 16,
    parameter int VERTS   = 3,
    parameter int COLOR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VERTS*3*W-1:0]     in_pos,
    input  logic [VERTS*COLOR_W-1:0] in_color,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [9*W-1:0]           r_mat,
    input  logic [3*W-1:0]           vec,
    output logic [VERTS*3*W-1:0]     out_pos,
    output logic [VERTS*COLOR_W-1:0] out_color,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int CNT_W = $clog2(VERTS + 3);
    localparam int ACC_W = 2*W + 2;
    localparam logic [CNT_W-1:0] N_VERTS  = CNT_W'(VERTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VERTS + 2);
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    // Overflow of a W+1-bit sum: the two top bits disagree.
    function automatic logic ovf_w1(input logic signed [W:0] v);
        return v[W] ^ v[W-1];
    endfunction

    function automatic logic signed [W-1:0] sat_w1(input logic signed [W:0] v);
        if (ovf_w1(v)) return v[W] ? MIN_V : MAX_V;
        return v[W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] t;
        t = acc + HALF;
        return t >>> FRAC_W;
    endfunction

    // The value fits in W bits only if every bit from position W-1 upward
    // equals the sign.
    function automatic logic ovf_acc(input logic signed [ACC_W-1:0] v);
        return !((&v[ACC_W-1:W-1]) || !(|v[ACC_W-1:W-1]));
    endfunction

    function automatic logic signed [W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
        if (ovf_acc(v)) return v[ACC_W-1] ? MIN_V : MAX_V;
        return v[W-1:0];
    endfunction

    function automatic logic signed [2*W-1:0] mul(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
        return ae * be;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             issue;

    logic [VERTS*3*W-1:0]     pos_in_q;
    logic [9*W-1:0]           r_q;
    logic [3*W-1:0]           vec_q;
    logic                     mode_q;
    logic [VERTS*3*W-1:0]     pos_q;
    logic [VERTS*COLOR_W-1:0] color_q;
    logic                     sat_q;

    logic                    vld_p0, vld_p1;
    logic [CNT_W-1:0]        idx_p0, idx_p1;
    logic signed [W-1:0]     d_p0   [3];
    logic signed [ACC_W-1:0] acc_p1 [3];

    logic [CNT_W-1:0]        vidx_c;
    logic signed [W-1:0]     p_c, v_c, coef_c, r1_c;
    logic signed [W:0]       diff_c, sum_c;
    logic signed [2*W-1:0]   prod_c;
    logic signed [ACC_W-1:0] sh_c;
    logic signed [W-1:0]     d_c   [3];
    logic signed [ACC_W-1:0] acc_c [3];
    logic signed [W-1:0]     res_c [3];
    logic                    ovf0_c, ovf2_c;

    assign in_ready  = !rst && ((state_q == IDLE) || (state_q == OUT && out_ready));
    assign accept    = in_valid && in_ready;
    assign issue     = (state_q == RUN) && (cnt_q < N_VERTS);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_pos   = pos_q;
    assign out_color = color_q;
    assign out_sat   = sat_q;

    // cnt_q counts RUN cycles; the final vertex is written at the end of
    // cycle VERTS+1 and one more cycle passes before OUT, giving an
    // accept-to-valid latency of VERTS+3.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = OUT;
            end
            OUT: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vidx_c = (cnt_q < N_VERTS) ? cnt_q : '0;
        p_c    = '0;
        v_c    = '0;
        coef_c = '0;
        r1_c   = '0;
        diff_c = '0;
        sum_c  = '0;
        prod_c = '0;
        sh_c   = '0;
        ovf0_c = 1'b0;
        ovf2_c = 1'b0;
        for (int a = 0; a < 3; a++) begin
            d_c[a]   = '0;
            acc_c[a] = '0;
            res_c[a] = '0;
        end

        // stage 0: translate
        for (int a = 0; a < 3; a++) begin
            p_c    = pos_in_q[(int'(vidx_c)*3 + a)*W +: W];
            v_c    = vec_q[a*W +: W];
            diff_c = {p_c[W-1], p_c} - {v_c[W-1], v_c};
            if (mode_q) begin
                d_c[a] = p_c;
            end else begin
                d_c[a] = sat_w1(diff_c);
                if (ovf_w1(diff_c)) ovf0_c = 1'b1;
            end
        end

        // stage 1: multiply-accumulate; camera mode walks columns (R^T)
        for (int a = 0; a < 3; a++) begin
            for (int j = 0; j < 3; j++) begin
                coef_c   = mode_q ? r_q[(3*a + j)*W +: W] : r_q[(3*j + a)*W +: W];
                prod_c   = mul(coef_c, d_p0[j]);
                acc_c[a] = acc_c[a] + {{2{prod_c[2*W-1]}}, prod_c};
            end
        end

        // stage 2: round, saturate, then add translation in model mode
        for (int a = 0; a < 3; a++) begin
            sh_c = round_shift(acc_p1[a]);
            r1_c = sat_acc(sh_c);
            if (ovf_acc(sh_c)) ovf2_c = 1'b1;
            if (mode_q) begin
                v_c      = vec_q[a*W +: W];
                sum_c    = {r1_c[W-1], r1_c} + {v_c[W-1], v_c};
                res_c[a] = sat_w1(sum_c);
                if (ovf_w1(sum_c)) ovf2_c = 1'b1;
            end else begin
                res_c[a] = r1_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_p0  <= issue;
            vld_p1  <= vld_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            pos_q   <= '0;
            color_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            if (accept) begin
                mode_q  <= mode;
                color_q <= in_color;
                sat_q   <= 1'b0;
            end else if ((issue && ovf0_c) || (vld_p1 && ovf2_c)) begin
                sat_q <= 1'b1;
            end
            if (vld_p1) begin
                for (int a = 0; a < 3; a++)
                    pos_q[(int'(idx_p1)*3 + a)*W +: W] <= res_c[a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pos_in_q <= in_pos;
            r_q      <= r_mat;
            vec_q    <= vec;
        end
        idx_p0 <= cnt_q;
        idx_p1 <= idx_p0;
        for (int a = 0; a < 3; a++) begin
            d_p0[a]   <= d_c[a];
            acc_p1[a] <= acc_c[a];
        end
    end

endmodule

// File: tb/tb_vertex_affine_transformer.sv
module tb_vertex_affine_transformer;

    localparam int W       = 32;
    localparam int FRAC_W  = 16;
    localparam int VERTS   = 3;
    localparam int COLOR_W = 16;

    typedef logic signed [127:0] big_t;

    typedef struct packed {
        logic             mode;
        logic [8:0][31:0] r;
        logic [2:0][31:0] vec;
        logic [8:0][31:0] pos;
        logic [47:0]      color;
    } prim_t;

    typedef struct packed {
        prim_t            p;
        logic [2:0][31:0] exp;
        logic             exp_sat;
    } vect_t;

    localparam big_t HI = 128'sd2147483647;
    localparam big_t LO = -128'sd2147483648;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [VERTS*3*W-1:0]     in_pos;
    logic [VERTS*COLOR_W-1:0] in_color;
    logic                     in_valid;
    logic                     in_ready;
    logic                     mode;
    logic [9*W-1:0]           r_mat;
    logic [3*W-1:0]           vec;
    logic [VERTS*3*W-1:0]     out_pos;
    logic [VERTS*COLOR_W-1:0] out_color;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;

    vertex_affine_transformer #(
        .W(W), .FRAC_W(FRAC_W), .VERTS(VERTS), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_pos(in_pos), .in_color(in_color),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .r_mat(r_mat), .vec(vec),
        .out_pos(out_pos), .out_color(out_color), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide-integer arithmetic with clamping by comparison.
    function automatic logic [31:0] clamp(input big_t v, inout logic s);
        if (v > HI) begin s = 1'b1; return 32'h7FFF_FFFF; end
        if (v < LO) begin s = 1'b1; return 32'h8000_0000; end
        return v[31:0];
    endfunction

    function automatic void model(input prim_t p, output logic [8:0][31:0] o, output logic s);
        big_t d [3];
        big_t pv, acc, coef, y;
        s = 1'b0;
        o = '0;
        for (int k = 0; k < VERTS; k++) begin
            for (int i = 0; i < 3; i++) begin
                pv = $signed(p.pos[3*k + i]);
                if (p.mode) d[i] = pv;
                else        d[i] = $signed(clamp(pv - $signed(p.vec[i]), s));
            end
            for (int a = 0; a < 3; a++) begin
                acc = 0;
                for (int j = 0; j < 3; j++) begin
                    coef = $signed(p.mode ? p.r[3*a + j] : p.r[3*j + a]);
                    acc  = acc + coef * d[j];
                end
                y = $signed(clamp((acc + (big_t'(1) <<< (FRAC_W - 1))) >>> FRAC_W, s));
                if (p.mode) y = $signed(clamp(y + $signed(p.vec[a]), s));
                o[3*k + a] = y[31:0];
            end
        end
    endfunction

    function automatic logic [8:0][31:0] rm(input logic [31:0] r11, r12, r13,
                                            input logic [31:0] r21, r22, r23,
                                            input logic [31:0] r31, r32, r33);
        return {r33, r32, r31, r23, r22, r21, r13, r12, r11};
    endfunction

    function automatic logic [2:0][31:0] v3(input logic [31:0] x, y, z);
        return {z, y, x};
    endfunction

    function automatic prim_t mkp(input logic m, input logic [8:0][31:0] r,
                                  input logic [2:0][31:0] v, input logic [2:0][31:0] p);
        prim_t q;
        q.mode  = m;
        q.r     = r;
        q.vec   = v;
        q.pos   = {p, p, p};
        q.color = {16'($urandom), 32'($urandom)};
        return q;
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 32'h0010_0000) - 32'h0008_0000;
    endfunction

    task automatic scramble();
        mode = 1'($urandom_range(0, 1));
        for (int k = 0; k < 9; k++) r_mat[k*32 +: 32] = $urandom;
        for (int k = 0; k < 3; k++) vec[k*32 +: 32] = $urandom;
    endtask

    // Called 1 time unit after a rising edge; returns 1 after the accepting edge.
    task automatic send(input string tag, input prim_t p);
        logic rdy;
        rdy = 1'b0;
        mode = p.mode; r_mat = p.r; vec = p.vec; in_pos = p.pos; in_color = p.color;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1 rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        check({tag, " accept"}, rdy, 1'b1);
        scramble();
    endtask

    task automatic collect(input string tag, input logic [8:0][31:0] exp_pos,
                           input logic [47:0] exp_col, input logic exp_sat, input int hold);
        int n;
        logic [VERTS*3*W-1:0]     pos0;
        logic [VERTS*COLOR_W-1:0] col0;
        logic                     s0, stable;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            scramble();
            n++;
        end
        check({tag, " latency"}, cyc - acc_cyc, VERTS + 3);
        for (int k = 0; k < VERTS; k++)
            check($sformatf("%s v%0d", tag, k), out_pos[k*96 +: 96], exp_pos[3*k +: 3]);
        check({tag, " color"}, out_color, exp_col);
        check({tag, " sat"}, out_sat, exp_sat);
        pos0 = out_pos; col0 = out_color; s0 = out_sat; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            scramble();
            if (out_valid !== 1'b1 || out_pos !== pos0 || out_color !== col0 ||
                out_sat !== s0 || in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check({tag, " hold"}, stable, 1'b1);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " drop"}, {out_valid, busy}, 2'b00);
    endtask

    vect_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]      one, zero;
        logic [8:0][31:0] ident, rot, exp9;
        logic             es, seen;
        prim_t            p, pb;

        one = 32'h0001_0000; zero = 32'h0;
        ident = rm(one, zero, zero, zero, one, zero, zero, zero, one);
        rot   = rm(zero, 32'hFFFF_0000, zero, one, zero, zero, zero, zero, one);

        tbl[0]  = '{mkp(0, ident, v3(32'h1_0000, 32'h2_0000, 32'h3_0000), v3(32'h5_0000, 32'h5_0000, 32'h5_0000)),
                    v3(32'h4_0000, 32'h3_0000, 32'h2_0000), 1'b0};
        tbl[1]  = '{mkp(0, rot, v3(0, 0, 0), v3(one, 0, 0)), v3(0, 32'hFFFF_0000, 0), 1'b0};
        tbl[2]  = '{mkp(1, rot, v3(0, 0, 32'hA_0000), v3(one, 0, 0)), v3(0, one, 32'hA_0000), 1'b0};
        tbl[3]  = '{mkp(1, rm(32'h8000, 0, 0, 0, one, 0, 0, 0, one), v3(0, 0, 0), v3(1, 0, 0)),
                    v3(1, 0, 0), 1'b0};
        tbl[4]  = '{mkp(1, rm(32'h2_0000, 0, 0, 0, 32'h2_0000, 0, 0, 0, 32'h2_0000), v3(0, 0, 0),
                        v3(32'h7FFF_0000, 0, 0)), v3(32'h7FFF_FFFF, 0, 0), 1'b1};
        tbl[5]  = '{mkp(0, ident, v3(32'h1_0000, 32'h2_0000, 32'h3_0000), v3(32'h5_0000, 32'h5_0000, 32'h5_0000)),
                    v3(32'h4_0000, 32'h3_0000, 32'h2_0000), 1'b0};
        tbl[6]  = '{mkp(0, ident, v3(one, 0, 0), v3(32'h8000_0000, 0, 0)), v3(32'h8000_0000, 0, 0), 1'b1};
        tbl[7]  = '{mkp(1, ident, v3(32'h8000_0000, 0, 0), v3(32'h8000_0000, 0, 0)), v3(32'h8000_0000, 0, 0), 1'b1};
        tbl[8]  = '{mkp(1, ident, v3(32'h7FFF_0000, 0, 0), v3(32'h7FFF_0000, 0, 0)), v3(32'h7FFF_FFFF, 0, 0), 1'b1};
        tbl[9]  = '{mkp(1, rm(32'h8000, 0, 0, 0, one, 0, 0, 0, one), v3(0, 0, 0), v3(32'hFFFF_FFFF, 0, 0)),
                    v3(0, 0, 0), 1'b0};
        tbl[10] = '{mkp(1, rm(32'h8000, 0, 0, 0, one, 0, 0, 0, one), v3(0, 0, 0), v3(32'hFFFF_FFFD, 0, 0)),
                    v3(32'hFFFF_FFFF, 0, 0), 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
        r_mat = '0; vec = '0; in_pos = '0; in_color = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset out_pos", out_pos[127:0] | out_pos[255:128] | 128'(out_pos[287:256]), 128'h0);
        check("reset color_sat", {out_color, out_sat}, 49'h0);
        rst = 1'b0;
        #1;
        check("idle in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            send($sformatf("tbl%0d", i), tbl[i].p);
            collect($sformatf("tbl%0d", i), {tbl[i].exp, tbl[i].exp, tbl[i].exp},
                    tbl[i].p.color, tbl[i].exp_sat, 0);
            release_out($sformatf("tbl%0d", i));
        end

        // Backpressure for 10 cycles, then handshake and a new accept in the same cycle.
        p  = mkp(0, ident, v3(32'h1_0000, 32'h2_0000, 32'h3_0000), v3(32'h5_0000, 32'h5_0000, 32'h5_0000));
        pb = mkp(0, rot, v3(0, 0, 0), v3(one, 0, 0));
        send("bp", p);
        collect("bp", {tbl[0].exp, tbl[0].exp, tbl[0].exp}, p.color, 1'b0, 10);
        out_ready = 1'b1;
        send("b2b", pb);
        out_ready = 1'b0;
        check("b2b drop", {out_valid, busy}, 2'b01);
        collect("b2b", {tbl[1].exp, tbl[1].exp, tbl[1].exp}, pb.color, 1'b0, 0);
        release_out("b2b");

        // Asynchronous reset two cycles after accept.
        p = mkp(1, rot, v3(0, 0, 32'hA_0000), v3(one, 0, 0));
        send("arst", p);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst busy_ready_valid", {busy, in_ready, out_valid}, 3'b000);
        check("arst out_pos", out_pos[127:0] | out_pos[255:128] | 128'(out_pos[287:256]), 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("arst no valid", seen, 1'b0);
        check("arst in_ready", in_ready, 1'b1);
        send("post", tbl[0].p);
        collect("post", {tbl[0].exp, tbl[0].exp, tbl[0].exp}, tbl[0].p.color, 1'b0, 0);
        release_out("post");

        // Random primitives against the reference model.
        for (int t = 0; t < 30; t++) begin
            p.mode  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 9; k++) p.r[k] = rnd_word();
            for (int k = 0; k < 3; k++) p.vec[k] = rnd_word();
            for (int k = 0; k < 9; k++) p.pos[k] = rnd_word();
            p.color = {16'($urandom), 32'($urandom)};
            model(p, exp9, es);
            send($sformatf("rnd%0d", t), p);
            collect($sformatf("rnd%0d", t), exp9, p.color, es, int'($urandom_range(0, 3)));
            release_out($sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertex_affine_transformer.md
# vertex_affine_transformer

Parametrised per-triangle affine vertex transform stage for the renderer transformer chain. It generalises the world→camera step: a run-time mode selects camera transform R^T·(p − C) or model transform R·p + T. Matrix, vector and mode are latched per triangle, and the datapath is configurable in width, fraction and vertex count, with round-to-nearest, saturation and full valid/ready backpressure. It sits between the model→world and projection stages; the same module is instantiated for both transform passes.

## Interface
- W, default 32: signed fixed-point word width of positions, matrix and vector elements.
- FRAC_W, default 16: fractional bits (default Q16.16).
- VERTS, default 3: vertices per primitive.
- COLOR_W, default 16: per-vertex colour width, passed through unchanged.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_pos  in  VERTS*3*W  vertex k, axis a (0=x, 1=y, 2=z) at bits [(3k+a)*W +: W].
- in_color  in  VERTS*COLOR_W  vertex k colour at [k*COLOR_W +: COLOR_W].
- in_valid  in  1  input primitive valid.
- in_ready  out  1  primitive accepted when in_valid && in_ready.
- mode  in  1  0 = camera, R^T·(p − vec); 1 = model, R·p + vec.
- r_mat  in  9*W  Rij (i, j = 1..3) at [(3(i−1)+(j−1))*W +: W], row-major.
- vec  in  3*W  C or T, x/y/z at [a*W +: W].
- out_pos  out  VERTS*3*W  transformed positions, same packing as in_pos.
- out_color  out  VERTS*COLOR_W  colours of the accepted primitive.
- out_sat  out  1  one or more components of this primitive saturated.
- out_valid  out  1  output primitive valid.
- out_ready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, OUT.
- IDLE → RUN on accept. On accept the block latches in_pos, in_color, r_mat, vec and mode, and clears sat.
- RUN: vertex k is issued into a 3-stage pipeline on cycle k of RUN (k = 0..VERTS−1). RUN → OUT when the last vertex leaves stage 2.
- Stage 0, translate:
  - Mode 0: d = p − vec, computed at W+1 bits and saturated to W.
  - Mode 1: d = p.
- Stage 1, multiply-accumulate:
  - Each product is 2W bits. The sum of three products is 2W+2 bits.
  - Mode 0 uses the columns of R: x' = R11·dx + R21·dy + R31·dz; y' uses R12/R22/R32; z' uses R13/R23/R33.
  - Mode 1 uses the rows of R: x' = R11·dx + R12·dy + R13·dz, and so on.
- Stage 2, round and saturate:
  - Add 2^(FRAC_W−1), arithmetic shift right by FRAC_W, saturate to signed W.
  - Mode 1 then adds vec at W+1 bits and saturates to W again.
  - Result is written to the out_pos slot of vertex k.
- Saturation limits are 0x7FFF_FFFF and 0x8000_0000 at W=32. Any saturation event sets sat. out_sat = sat.
- OUT: out_valid = 1 and outputs are held stable.
  - On out_ready with no new accept: OUT → IDLE.
  - in_ready = (state == IDLE) || (state == OUT && out_ready). An accept in OUT goes directly to RUN.
- Colours are copied from the latch unchanged.
- Changes on r_mat, vec or mode after accept have no effect on the primitive in flight.

## Timing
- Reset state: IDLE. out_valid = 0, out_pos = 0, out_color = 0, out_sat = 0, busy = 0. in_ready = 0 while rst is high.
- Reset mid-operation aborts the primitive. It is never emitted, and no partial out_valid occurs.
- Latency: accept on edge t → out_valid high after edge t + VERTS + 3. This is 6 cycles at VERTS = 3.
- Throughput with out_ready held high: one primitive per VERTS + 4 cycles.
- out_valid stays high, with out_pos, out_color and out_sat stable, until the cycle in which out_ready = 1.
- out_valid drops on the following edge unless that same cycle also accepted a new primitive. In that case out_valid still drops, because the new result needs VERTS + 3 cycles.
- in_valid asserted while in RUN is ignored; upstream must hold it.
- busy is high from the edge after accept through the edge of the output handshake.

## Test plan
- Identity translate: mode 0, R = I (diagonal 0x0001_0000), vec = (1.0, 2.0, 3.0), all vertices (5.0, 5.0, 5.0) → every vertex (4.0, 3.0, 2.0). out_valid exactly 6 cycles after accept. out_sat = 0.
- Transpose check: R = [[0, −1, 0], [1, 0, 0], [0, 0, 1]], p = (1.0, 0, 0).
  - Mode 0, vec = 0 → (0, 0xFFFF_0000, 0).
  - Mode 1, vec = (0, 0, 10.0) → (0, 1.0, 10.0).
- Rounding: mode 1, R11 = 0x0000_8000, R22 = R33 = 0x0001_0000, p.x = 0x0000_0001 → x' = 0x0000_0001.
- Saturation: mode 1, R = 2·I, p.x = 0x7FFF_0000 → x' = 0x7FFF_FFFF and out_sat = 1. The next clean primitive gives out_sat = 0.
- Backpressure and latching:
  - Hold out_ready = 0 for 10 cycles and change r_mat and vec during RUN.
  - Required: outputs stay stable, results use the latched values, in_ready = 0.
  - Then assert out_ready with in_valid high: the second primitive is accepted in the handshake cycle, and its result appears 6 cycles later.
- Async reset: assert rst 2 cycles after accept → out_valid stays 0, and busy and in_ready go to 0 immediately. After release, in_ready = 1 and a new primitive completes correctly.
